boid_position_reader: RTL

- Readback path for boid positions: the CPU→BPU path writes them; this block reads them back.
- On a start pulse it steps a select index through all BPUs and captures each boid's live x/y into a back buffer.
- On completion the back buffer swaps with a front buffer that the CPU side reads by index.
- Sits beside the BPU array in the top level; drives the BPU output-mux select and exposes a snapshot to the CPU/debug logic.

---
 rtl/boid_position_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/boid_position_reader.sv
// Boid position snapshot reader: scans every BPU through the output mux into a back
// buffer, then swaps it to the CPU-visible front buffer. Optional BOID_READER_AUTO_SNAPSHOT_EN.
module boid_position_reader #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int X_WIDTH        = 10,
  parameter int Y_WIDTH        = 9
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  input  logic [X_WIDTH-1:0]        boid_x_in,
  input  logic [Y_WIDTH-1:0]        boid_y_in,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               snapshot_count,
  input  logic [BITS_FOR_BOIDS:0]   rd_index,
  output logic [31:0]               rd_x,
  output logic [31:0]               rd_y,
  output logic                      rd_valid,
  input  logic                      screen_end
);

  localparam int ENTRY_W = X_WIDTH + Y_WIDTH;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, SWAP} state_t;

  state_t               state, state_next;
  logic                 start_req;
  logic                 last_boid;
  logic                 capture_en;
  logic                 swap_en;
  logic                 buf_sel;
  logic [ENTRY_W-1:0]   bank [2][MAX_BOIDS];
  logic [ENTRY_W-1:0]   rd_entry;
  logic                 rd_in_range;

`ifdef BOID_READER_AUTO_SNAPSHOT_EN
  // A frame-end pulse in IDLE behaves exactly like start; ignored while scanning.
  assign start_req = start | screen_end;
`else
  logic unused_screen_end;
  assign unused_screen_end = screen_end;
  assign start_req = start;
`endif

  assign last_boid = (boid_sel == BITS_FOR_BOIDS'(MAX_BOIDS - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req) state_next = SETTLE;
      SETTLE:  state_next = CAPTURE;
      CAPTURE: state_next = last_boid ? SWAP : SETTLE;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    capture_en = (state == CAPTURE);
    swap_en    = (state == SWAP);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      boid_sel       <= '0;
      done           <= 1'b0;
      snapshot_count <= 16'd0;
      rd_valid       <= 1'b0;
      buf_sel        <= 1'b0;
    end else begin
      done <= swap_en;
      if (state == IDLE && start_req) boid_sel <= '0;
      if (capture_en && !last_boid)   boid_sel <= boid_sel + 1'b1;
      if (swap_en) begin
        buf_sel        <= ~buf_sel;
        snapshot_count <= snapshot_count + 16'd1;
        rd_valid       <= 1'b1;
        boid_sel       <= '0;
      end
    end
  end

  // NOTE: the buffer storage is deliberately not reset; rd_valid tells consumers when it is meaningful.
  // Only the back bank is ever written, so the CPU never sees a half-updated snapshot.
  always_ff @(posedge clock) begin
    if (capture_en && !reset) bank[~buf_sel][boid_sel] <= {boid_x_in, boid_y_in};
  end

  assign rd_in_range = (rd_index < (BITS_FOR_BOIDS + 1)'(MAX_BOIDS));

  always_comb begin
    rd_entry = bank[buf_sel][rd_index[BITS_FOR_BOIDS-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_x <= 32'd0;
      rd_y <= 32'd0;
    end else if (!rd_in_range) begin
      rd_x <= 32'd0;
      rd_y <= 32'd0;
    end else begin
      rd_x <= {{(32 - X_WIDTH){1'b0}}, rd_entry[ENTRY_W-1:Y_WIDTH]};
      rd_y <= {{(32 - Y_WIDTH){1'b0}}, rd_entry[Y_WIDTH-1:0]};
    end
  end

endmodule
